// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with valid/ready on both sides.
// Back-to-back words stream without a bubble via the last-bit reload path.
module piso_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic accept;
  logic xfer;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dout_valid = (state_q == SHIFT);
    dout_last  = dout_valid && (cnt_q == LAST_IDX);
    if (!dout_valid) begin
      dout = 1'b0;
    end else if (MSB_FIRST) begin
      dout = shreg_q[DATA_WIDTH-1];
    end else begin
      dout = shreg_q[0];
    end
    // Ready is gated by resetn so no word is accepted while reset is held.
    if (!resetn) begin
      din_ready = 1'b0;
    end else if (state_q == IDLE) begin
      din_ready = 1'b1;
    end else begin
      din_ready = dout_last && dout_ready;
    end
    accept = din_valid && din_ready;
    xfer   = dout_valid && dout_ready;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (dout_last) begin
            if (accept) begin
              shreg_d = din;
              cnt_d   = '0;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            if (MSB_FIRST) begin
              shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two 6-bit instances (MSB-first and LSB-first)
// checked through a per-instance scoreboard of expected {last, bit} pairs.
module tb_piso_serializer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;

  logic [W-1:0] din_a = '0, din_b = '0;
  logic         din_valid_a = 1'b0, din_valid_b = 1'b0;
  logic         dout_ready_a = 1'b1, dout_ready_b = 1'b1;
  logic         din_ready_a, din_ready_b;
  logic         dout_a, dout_b;
  logic         dout_valid_a, dout_valid_b;
  logic         dout_last_a, dout_last_b;

  int checks = 0;
  int failures = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .resetn(resetn),
    .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .dout_last(dout_last_a)
  );

  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .resetn(resetn),
    .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .dout_last(dout_last_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Negedge monitor: pop on a pending transfer, push a word's bits on a pending accept.
  always @(negedge clk) begin
    if (resetn) begin
      if (dout_valid_a && dout_ready_a) begin
        if (q_a.size() == 0) check_val("msb_unexpected_bit", {dout_last_a, dout_a}, 2'bxx);
        else check_val("msb_bit", {dout_last_a, dout_a}, q_a.pop_front());
      end
      if (!dout_valid_a) check_val("msb_dout_zero_when_idle", dout_a, 1'b0);
      if (dout_valid_b && dout_ready_b) begin
        if (q_b.size() == 0) check_val("lsb_unexpected_bit", {dout_last_b, dout_b}, 2'bxx);
        else check_val("lsb_bit", {dout_last_b, dout_b}, q_b.pop_front());
      end
      if (din_valid_a && din_ready_a)
        for (int i = 0; i < W; i++) q_a.push_back({1'(i == W-1), din_a[W-1-i]});
      if (din_valid_b && din_ready_b)
        for (int i = 0; i < W; i++) q_b.push_back({1'(i == W-1), din_b[i]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [W-1:0] w);
    int n;
    din_a = w;
    din_valid_a = 1'b1;
    n = 0;
    while (!din_ready_a && n < 50) begin tick(); n++; end
    if (n >= 50) check_val("send_a_timeout", 0, 1);
    tick();
    din_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (dout_valid_a && n < 100) begin tick(); n++; end
    check_val("wait_idle_a", dout_valid_a, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_valid", dout_valid_a, 1'b0);
    check_val("rst_dout", dout_a, 1'b0);
    check_val("rst_last", dout_last_a, 1'b0);
    check_val("rst_din_ready", din_ready_a, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    #1;
    check_val("post_rst_ready", din_ready_a, 1'b1);
    tick();

    // MSB-first basic stream with constant dout_ready
    send_a(6'b101100);
    for (int k = 0; k < W; k++) begin
      check_val("t1_valid", dout_valid_a, 1'b1);
      check_val("t1_last", dout_last_a, 1'(k == W-1));
      check_val("t1_din_ready", din_ready_a, 1'(k == W-1));
      tick();
    end
    check_val("t1_valid_after", dout_valid_a, 1'b0);
    tick();

    // LSB-first on the second instance
    din_b = 6'b101100;
    din_valid_b = 1'b1;
    tick();
    din_valid_b = 1'b0;
    for (int k = 0; k < W; k++) begin
      check_val("t2_valid", dout_valid_b, 1'b1);
      check_val("t2_last", dout_last_b, 1'(k == W-1));
      tick();
    end
    check_val("t2_valid_after", dout_valid_b, 1'b0);
    tick();

    // Backpressure on the third bit
    send_a(6'b101100);
    tick(); tick();
    dout_ready_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("t3_hold_dout", dout_a, 1'b1);
      check_val("t3_hold_valid", dout_valid_a, 1'b1);
      check_val("t3_hold_din_ready", din_ready_a, 1'b0);
      tick();
    end
    dout_ready_a = 1'b1;
    wait_idle_a();
    tick();

    // Back-to-back words, din_valid held
    send_a(6'b111000);
    din_a = 6'b010101;
    din_valid_a = 1'b1;
    for (int k = 0; k < 2*W; k++) begin
      check_val("t4_valid", dout_valid_a, 1'b1);
      check_val("t4_last", dout_last_a, 1'(k == W-1 || k == 2*W-1));
      if (k < W) check_val("t4_din_ready", din_ready_a, 1'(k == W-1));
      tick();
      if (k == W-1) din_valid_a = 1'b0;
    end
    check_val("t4_valid_after", dout_valid_a, 1'b0);
    tick();

    // Asynchronous reset mid-word
    send_a(6'b101100);
    tick(); tick(); tick();
    #2;
    resetn = 1'b0;
    #1;
    check_val("t5_valid", dout_valid_a, 1'b0);
    check_val("t5_dout", dout_a, 1'b0);
    check_val("t5_last", dout_last_a, 1'b0);
    check_val("t5_din_ready", din_ready_a, 1'b0);
    q_a.delete();
    tick(); tick();
    resetn = 1'b1;
    #1;
    check_val("t5_ready_after", din_ready_a, 1'b1);
    check_val("t5_valid_after", dout_valid_a, 1'b0);
    tick();
    send_a(6'b000011);
    wait_idle_a();
    tick();

    // din toggling without din_valid must not start anything
    for (int k = 0; k < 10; k++) begin
      din_a = W'($urandom);
      tick();
      check_val("t6_valid", dout_valid_a, 1'b0);
      check_val("t6_ready", din_ready_a, 1'b1);
    end

    tick();
    check_val("sb_a_drained", q_a.size(), 0);
    check_val("sb_b_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
